instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 10'h000: fetch address loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 4: prefetch buffer entries, power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 fetch_en  input  1  high permits new memory requests.
REQ-006 redirect_valid  input  1  one-cycle pulse; flush and restart fetch at redirect_pc.
REQ-007 redirect_pc  input  10  new fetch address, sampled when redirect_valid=1.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  10  word address of the request.
REQ-010 imem_ack  input  1  memory completes the request this cycle.
REQ-011 imem_rdata  input  30  instruction word; valid only when imem_ack=1.
REQ-012 instr_valid  output  1  instruction holds a real fetched word.
REQ-013 instruction  output  30  FIFO head word, or 30'h0 (flag 00 = no-op) when empty.
REQ-014 instr_pc  output  10  address of the word on instruction; 0 when empty.
REQ-015 instr_ready  input  1  downstream decode stage accepts the word.

Function
REQ-016 State machine states: FETCH (no request outstanding), WAIT_ACK (request outstanding, data kept), DISCARD (request outstanding, data dropped).
REQ-017 FETCH: assert imem_req with imem_addr=pc when fetch_en=1 and (fifo_count + 0 outstanding) < FIFO_DEPTH; enter WAIT_ACK.
REQ-018 WAIT_ACK: hold imem_req=1 and imem_addr stable until imem_ack; an ack in the first request cycle is legal.
REQ-019 On imem_ack in WAIT_ACK, push {pc, imem_rdata}, pc <= pc+1 mod 1024, return to FETCH; the next request issues no earlier than the following cycle.
REQ-020 At most one request outstanding; space is reserved at issue, so a push never meets a full FIFO.
REQ-021 Pop when instr_valid && instr_ready; push and pop in the same cycle leave fifo_count unchanged.
REQ-022 instr_valid = (fifo_count != 0); instruction and instr_pc are combinational from the FIFO head.
REQ-023 Latency: word acked at edge N is visible on instruction after edge N (valid in cycle N+1) when FIFO was empty.
REQ-024 redirect_valid has priority over push, pop and issue in the same cycle: FIFO cleared, pc <= redirect_pc.
REQ-025 Redirect in WAIT_ACK without same-cycle ack -> DISCARD; with same-cycle ack -> data dropped, state FETCH.
REQ-026 DISCARD: hold imem_addr stable, keep imem_req=1 until imem_ack, drop imem_rdata, then FETCH.
REQ-027 Redirect in DISCARD updates pc only and stays in DISCARD.
REQ-028 fetch_en=0 blocks new issue only; an outstanding request completes normally.
REQ-029 pc wraps 10'h3FF -> 10'h000 without any flag.

Reset
REQ-030 While rst_n=0: state FETCH, pc=RESET_PC, FIFO empty, imem_req=0, imem_addr=0, instr_valid=0, instruction=0, instr_pc=0.
REQ-031 Reset asserted mid-request abandons the request immediately; any ack during reset is ignored.
REQ-032 First imem_req may assert in the first cycle after rst_n rises.

Structure
REQ-033 Shared package holds: PC_W=10, INSTR_W=30, NOP_INSTR=30'h0, and the fetch state enum.
REQ-034 Prefetch buffer is one sub-module, fetch_fifo (sync FIFO with flush, count output), instantiated once.

Verification
REQ-035 Reset release, imem_ack=1 every request, instr_ready=1 -> addresses 0,1,2,... issued; instruction equals rdata in order with instr_pc matching.
REQ-036 instr_ready=0, FIFO_DEPTH=4 -> exactly 4 requests issued, then imem_req stays 0; raising instr_ready drains 4 words in order.
REQ-037 Ack delayed 3 cycles, redirect_valid with redirect_pc=10'h100 in cycle 1 -> late rdata dropped, next imem_addr=10'h100.
REQ-038 Redirect to 10'h3FE with ack every request -> imem_addr sequence 3FE, 3FF, 000, 001.
REQ-039 FIFO empty -> instr_valid=0, instruction=30'h0; FIFO full with simultaneous pop and ack -> count unchanged, no word lost.
REQ-040 rst_n driven low while imem_req=1 -> imem_req=0 and instr_valid=0 immediately, pc=RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds address/word widths, the no-op encoding, the fetch FSM states and the buffer entry layout.
package instr_fetch_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 30;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 30'h0;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DISCARD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

  // Sequential fetch address; wraps silently at the top of the 1K-word space.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + 10'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and instruction memory.
// master = fetch side, slave = memory side.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, word} entries with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           do_push_s;
  logic           do_pop_s;

  // Qualify push/pop: flush wins, and full/empty guards keep the pointers coherent.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_push_s = push && (count_r != CW'(DEPTH));
      do_pop_s  = pop && (count_r != CW'(0));
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, cleared on reset so the head never carries stale X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single outstanding memory requests, buffers returned words,
// and presents them in order to decode; redirects flush the buffer and squash in-flight data.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 10'h000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  instr_fetch_if.master      imem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_r;
  fetch_state_e    state_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_s;
  logic            req_r;
  logic            req_s;
  logic [PC_W-1:0] addr_r;
  logic [PC_W-1:0] addr_s;

  logic            push_s;
  logic            pop_s;
  logic            room_s;
  logic            valid_s;
  fetch_entry_t    push_data_s;
  fetch_entry_t    head_s;
  logic [CW-1:0]   fifo_count_s;

  assign valid_s     = (fifo_count_s != CW'(0));
  // Only FETCH can issue, so nothing is outstanding and the count alone decides room.
  assign room_s      = (fifo_count_s < CW'(FIFO_DEPTH));
  assign pop_s       = valid_s && instr_ready && !redirect_valid;
  assign push_data_s = '{pc: pc_r, word: imem.imem_rdata};

  // Next-state, next-pc and request decode for the fetch FSM.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    req_s   = req_r;
    addr_s  = addr_r;
    push_s  = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_s = redirect_pc;
        end else if (fetch_en && room_s) begin
          req_s   = 1'b1;
          addr_s  = pc_r;
          state_s = ST_WAIT_ACK;
        end else begin
          req_s = 1'b0;
        end
      end
      ST_WAIT_ACK: begin
        if (imem.imem_ack) begin
          req_s   = 1'b0;
          state_s = ST_FETCH;
          if (redirect_valid) begin
            pc_s = redirect_pc;
          end else begin
            push_s = 1'b1;
            pc_s   = pc_incr(pc_r);
          end
        end else if (redirect_valid) begin
          pc_s    = redirect_pc;
          state_s = ST_DISCARD;
        end else begin
          req_s = 1'b1;
        end
      end
      ST_DISCARD: begin
        // The returning word belongs to the squashed path; pc already holds the new target.
        if (redirect_valid) begin
          pc_s = redirect_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem.imem_ack) begin
          req_s   = 1'b0;
          state_s = ST_FETCH;
        end else begin
          req_s = 1'b1;
        end
      end
      default: begin
        req_s   = 1'b0;
        state_s = ST_FETCH;
      end
    endcase
  end

  // FSM, fetch pointer and registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      req_r   <= 1'b0;
      addr_r  <= 10'h000;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      req_r   <= req_s;
      addr_r  <= addr_s;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s)
  );

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = addr_r;
  assign instr_valid    = valid_s;
  assign instruction    = valid_s ? head_s.word : NOP_INSTR;
  assign instr_pc       = valid_s ? head_s.pc : 10'h000;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, corner-case sequences, and random traffic
// checked against a transaction-level queue model of the fetch/deliver rules.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               fetch_en;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC   (10'h000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INSTR_W-1:0] word_of(input logic [PC_W-1:0] a);
    return {a, ~a, 10'h2A5};
  endfunction

  // ---------------- memory responder ----------------
  bit auto_resp = 1'b0;
  bit rand_delay = 1'b0;
  int fix_delay = 0;
  bit r_busy = 1'b0;
  int r_cnt = 0;
  int r_d = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      if (bus.imem_req) begin
        if (!r_busy) begin
          r_busy = 1'b1;
          r_cnt  = 0;
          r_d    = rand_delay ? int'($urandom_range(0, 3)) : fix_delay;
        end
        if (r_cnt == r_d) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = 30'($urandom);
          r_busy         = 1'b0;
        end else begin
          bus.imem_ack = 1'b0;
          r_cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        r_busy       = 1'b0;
      end
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] data;
  } ent_t;

  ent_t            mq[$];
  bit              chk_en = 1'b0;
  bit              m_out, m_live, m_could;
  logic [PC_W-1:0] m_cur, m_exp;
  int              n_new_req = 0;
  logic [PC_W-1:0] last_new_addr = 10'h000;

  task automatic model_reset();
    mq.delete();
    m_out   = 1'b0;
    m_live  = 1'b0;
    m_could = 1'b0;
    m_cur   = 10'h000;
    m_exp   = 10'h000;
  endtask

  task automatic check_cycle();
    logic req;
    req = bus.imem_req;
    cmp("instr_valid", 40'(instr_valid), 40'(mq.size() != 0));
    if (mq.size() != 0) begin
      cmp("instr_pc", 40'(instr_pc), 40'(mq[0].pc));
      cmp("instruction", 40'(instruction), 40'(mq[0].data));
    end else begin
      cmp("instr_pc_empty", 40'(instr_pc), 40'(0));
      cmp("instruction_nop", 40'(instruction), 40'(0));
    end
    if (m_out) begin
      cmp("req_hold", 40'(req), 40'(1));
      cmp("addr_hold", 40'(bus.imem_addr), 40'(m_cur));
    end else if (m_could) begin
      cmp("req_issue", 40'(req), 40'(1));
      cmp("addr_issue", 40'(bus.imem_addr), 40'(m_exp));
    end else begin
      cmp("req_idle", 40'(req), 40'(0));
    end
    if (!m_out && req) begin
      m_out         = 1'b1;
      m_live        = 1'b1;
      m_cur         = bus.imem_addr;
      last_new_addr = bus.imem_addr;
      n_new_req++;
    end
    // Effects of the coming clock edge: pop, then push, then redirect flush.
    m_could = !req && fetch_en && !redirect_valid && (mq.size() < DEPTH);
    if (!redirect_valid && instr_ready && mq.size() != 0) begin
      void'(mq.pop_front());
    end
    if (req && bus.imem_ack) begin
      if (m_live && !redirect_valid) begin
        mq.push_back('{m_cur, bus.imem_rdata});
        m_exp = m_cur + 10'd1;
      end
      m_out  = 1'b0;
      m_live = 1'b0;
    end
    if (redirect_valid) begin
      mq.delete();
      m_live = 1'b0;
      m_exp  = redirect_pc;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        check_cycle();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- directed table ----------------
  typedef struct {
    bit              fe;
    bit              rv;
    logic [PC_W-1:0] rpc;
    bit              ack;
    bit              rdy;
    bit              e_req;
    logic [PC_W-1:0] e_addr;
    bit              e_v;
    logic [PC_W-1:0] e_pc;
  } vec_t;

  vec_t tv[14];

  initial begin
    int n0;
    int n1;
    bit hit;

    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 10'h000;
    instr_ready    = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 30'h0;
    model_reset();

    tv[0]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000};
    tv[1]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000};
    tv[2]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h000};
    tv[3]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h001, 1'b0, 10'h000};
    tv[4]  = '{1'b1, 1'b1, 10'h3FE, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h001};
    tv[5]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000};
    tv[6]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h3FE, 1'b0, 10'h000};
    tv[7]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h3FE};
    tv[8]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h3FF, 1'b0, 10'h000};
    tv[9]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h3FF};
    tv[10] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000};
    tv[11] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h000};
    tv[12] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h001, 1'b0, 10'h000};
    tv[13] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h001};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_req", 40'(bus.imem_req), 40'(0));
    cmp("rst_addr", 40'(bus.imem_addr), 40'(0));
    cmp("rst_valid", 40'(instr_valid), 40'(0));
    cmp("rst_instruction", 40'(instruction), 40'(0));
    cmp("rst_instr_pc", 40'(instr_pc), 40'(0));

    // Sequential fetch from reset, then redirect across the 3FF->000 wrap
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 0) begin
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
      end
      fetch_en       = tv[i].fe;
      redirect_valid = tv[i].rv;
      redirect_pc    = tv[i].rpc;
      instr_ready    = tv[i].rdy;
      bus.imem_ack   = tv[i].ack;
      if (tv[i].ack) begin
        bus.imem_rdata = word_of(tv[i].e_addr);
      end
      @(negedge clk);
      cmp("tv_req", 40'(bus.imem_req), 40'(tv[i].e_req));
      if (tv[i].e_req) begin
        cmp("tv_addr", 40'(bus.imem_addr), 40'(tv[i].e_addr));
      end
      cmp("tv_valid", 40'(instr_valid), 40'(tv[i].e_v));
      cmp("tv_instr_pc", 40'(instr_pc), 40'(tv[i].e_v ? tv[i].e_pc : 10'h000));
      cmp("tv_instruction", 40'(instruction), 40'(tv[i].e_v ? word_of(tv[i].e_pc) : 30'h0));
    end

    // Drain to empty: no-op presented
    auto_resp  = 1'b1;
    rand_delay = 1'b0;
    fix_delay  = 0;
    tick();
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    #1;
    cmp("empty_valid", 40'(instr_valid), 40'(0));
    cmp("empty_nop", 40'(instruction), 40'(0));

    // Stalled decode: exactly DEPTH requests, then drain in order (next pc is 003)
    tick();
    instr_ready = 1'b0;
    fetch_en    = 1'b1;
    n0 = n_new_req;
    repeat (30) tick();
    @(negedge clk);
    #1;
    cmp("stall_req_count", 40'(n_new_req - n0), 40'(DEPTH));
    cmp("stall_req_low", 40'(bus.imem_req), 40'(0));
    tick();
    instr_ready = 1'b1;
    fetch_en    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      @(negedge clk);
      cmp("drain_pc", 40'(instr_pc), 40'(10'h003 + 10'(k)));
    end
    tick();
    @(negedge clk);
    cmp("drain_empty", 40'(instr_valid), 40'(0));

    // Full buffer with pop and ack in the same cycle: no word lost
    tick();
    fix_delay   = 2;
    instr_ready = 1'b0;
    fetch_en    = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      tick();
      if (bus.imem_ack && mq.size() == 3) begin
        instr_ready = 1'b1;
        hit = 1'b1;
      end
    end
    cmp("full_push_pop_seen", 40'(hit), 40'(1));
    tick();
    instr_ready = 1'b0;
    fetch_en    = 1'b0;
    @(negedge clk);
    cmp("full_head_pc", 40'(instr_pc), 40'(10'h008));
    tick();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick();
      @(negedge clk);
      cmp("full_drain_pc", 40'(instr_pc), 40'(10'h008 + 10'(k)));
    end
    tick();
    @(negedge clk);
    cmp("full_drain_empty", 40'(instr_valid), 40'(0));

    // Redirect while a slow request is outstanding: late data dropped
    tick();
    fix_delay = 3;
    fetch_en  = 1'b1;
    n0 = n_new_req;
    for (int k = 0; k < 20 && n_new_req <= n0; k++) tick();
    cmp("redir_first_req_seen", 40'(n_new_req > n0), 40'(1));
    redirect_valid = 1'b1;
    redirect_pc    = 10'h100;
    tick();
    redirect_valid = 1'b0;
    n1 = n_new_req;
    for (int k = 0; k < 20 && n_new_req <= n1; k++) tick();
    cmp("redir_next_req_seen", 40'(n_new_req > n1), 40'(1));
    cmp("redir_next_addr", 40'(last_new_addr), 40'(10'h100));

    // Reset asserted mid-request
    n0 = n_new_req;
    for (int k = 0; k < 20 && n_new_req <= n0; k++) tick();
    cmp("rst_mid_req_seen", 40'(bus.imem_req), 40'(1));
    #2;
    rst_n = 1'b0;
    #1;
    cmp("rst_mid_req", 40'(bus.imem_req), 40'(0));
    cmp("rst_mid_valid", 40'(instr_valid), 40'(0));
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b1;
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    model_reset();
    n0 = n_new_req;
    for (int k = 0; k < 20 && n_new_req <= n0; k++) tick();
    cmp("rst_release_req_seen", 40'(n_new_req > n0), 40'(1));
    cmp("rst_release_addr", 40'(last_new_addr), 40'(10'h000));

    // Random traffic against the model
    rand_delay = 1'b1;
    for (int k = 0; k < 800; k++) begin
      tick();
      fetch_en       = ($urandom_range(0, 4) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 10'(10'h3FC + 10'($urandom_range(0, 3)))
                                                   : 10'($urandom);
    end
    tick();
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    #1;
    cmp("final_empty", 40'(instr_valid), 40'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
